// File: rtl/ac97_cmd_scheduler.sv
// ac97_cmd_scheduler
// Owns AC-link slots 1/2 in both directions. It takes one CSR register access at
// a time, puts the command into the next outgoing frame, and for reads waits for
// the matching status reply in incoming frames. A reply that has not arrived
// after TIMEOUT_FRAMES incoming frames completes the read with 16'hFFFF.
//
// Optional build macro: AC97_CMD_RETRY_EN. When it is defined, the first read
// timeout resends the same command once, and only a second timeout is reported.
module ac97_cmd_scheduler #(
  parameter int unsigned TIMEOUT_FRAMES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_stb,
  input  logic        req_we,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ack,
  output logic        busy,
  output logic        rsp_stb,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  input  logic        down_next_frame,
  output logic        down_addr_valid,
  output logic [19:0] down_addr,
  output logic        down_data_valid,
  output logic [19:0] down_data,
  input  logic        up_next_frame,
  input  logic        up_frame_valid,
  input  logic        up_addr_valid,
  input  logic        up_data_valid,
  input  logic [19:0] up_addr,
  input  logic [19:0] up_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_FRAMES);

  state_t      state;
  logic        cmd_we;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [7:0]  frame_cnt;
`ifdef AC97_CMD_RETRY_EN
  logic        retried;
`endif

  logic reply_match;
  logic timeout_hit;

  // Reply qualification and "this mismatched frame is the last one we wait for".
  assign reply_match = up_frame_valid & up_addr_valid & up_data_valid &
                       (up_addr[18:12] == cmd_addr);
  assign timeout_hit = ((frame_cnt + 8'd1) == TIMEOUT_CNT);

  // busy is derived from the registered state, so it is glitch-free.
  assign busy = (state != IDLE);

  // Command FSM with registered slot and response outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      cmd_we          <= 1'b0;
      cmd_addr        <= '0;
      cmd_wdata       <= '0;
      frame_cnt       <= '0;
      req_ack         <= 1'b0;
      rsp_stb         <= 1'b0;
      rsp_data        <= '0;
      rsp_timeout     <= 1'b0;
      down_addr_valid <= 1'b0;
      down_addr       <= '0;
      down_data_valid <= 1'b0;
      down_data       <= '0;
`ifdef AC97_CMD_RETRY_EN
      retried         <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the branch
      // that wants them; later non-blocking writes in the same block win.
      req_ack <= 1'b0;
      rsp_stb <= 1'b0;

      case (state)
        IDLE: begin
          frame_cnt <= '0;
          if (req_stb) begin
            cmd_we          <= req_we;
            cmd_addr        <= req_addr;
            cmd_wdata       <= req_wdata;
            req_ack         <= 1'b1;
            down_addr_valid <= 1'b1;
            down_addr       <= {~req_we, req_addr, 12'h000};
            down_data_valid <= req_we;
            down_data       <= {req_wdata, 4'h0};
`ifdef AC97_CMD_RETRY_EN
            retried         <= 1'b0;
`endif
            state           <= ISSUE;
          end
        end

        ISSUE: begin
          // The framer has latched the slots; they must not go out twice.
          if (down_next_frame) begin
            down_addr_valid <= 1'b0;
            down_addr       <= '0;
            down_data_valid <= 1'b0;
            down_data       <= '0;
            if (cmd_we) begin
              rsp_stb     <= 1'b1;
              rsp_data    <= '0;
              rsp_timeout <= 1'b0;
              state       <= DONE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (up_next_frame) begin
            if (reply_match) begin
              rsp_stb     <= 1'b1;
              rsp_data    <= up_data[19:4];
              rsp_timeout <= 1'b0;
              state       <= DONE;
            end else begin
              // Counter stops at TIMEOUT_FRAMES because the state is left here.
              frame_cnt <= frame_cnt + 8'd1;
              if (timeout_hit) begin
`ifdef AC97_CMD_RETRY_EN
                if (!retried) begin
                  retried         <= 1'b1;
                  frame_cnt       <= '0;
                  down_addr_valid <= 1'b1;
                  down_addr       <= {~cmd_we, cmd_addr, 12'h000};
                  down_data_valid <= cmd_we;
                  down_data       <= {cmd_wdata, 4'h0};
                  state           <= ISSUE;
                end else begin
                  rsp_stb     <= 1'b1;
                  rsp_data    <= 16'hFFFF;
                  rsp_timeout <= 1'b1;
                  state       <= DONE;
                end
`else
                rsp_stb     <= 1'b1;
                rsp_data    <= 16'hFFFF;
                rsp_timeout <= 1'b1;
                state       <= DONE;
`endif
              end
            end
          end
        end

        DONE: begin
          // rsp_stb is high for exactly this cycle.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
